// File: rtl/bp_be_fe_feedback_gen.sv
// Turns resolved-branch results into FE redirect pulses and a buffered attaboy stream.
// Optional perf counters are enabled by defining BP_FE_FEEDBACK_PERF_EN.
module bp_be_fe_feedback_gen #(
  parameter int vaddr_width_p               = 39,
  parameter int branch_metadata_fwd_width_p = 64,
  parameter int attaboy_els_p               = 4
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic                                   fe_init_done_i,
  input  logic                                   br_v_i,
  input  logic [vaddr_width_p-1:0]               br_pc_i,
  input  logic [branch_metadata_fwd_width_p-1:0] br_metadata_i,
  input  logic                                   br_taken_i,
  input  logic                                   br_nonbr_i,
  input  logic                                   br_mispredict_i,
  input  logic                                   br_resume_i,
  input  logic                                   cmd_redirect_v_i,
  input  logic [vaddr_width_p-1:0]               cmd_redirect_pc_i,
  output logic                                   redirect_v_o,
  output logic [vaddr_width_p-1:0]               redirect_pc_o,
  output logic                                   redirect_resume_o,
  output logic                                   redirect_br_v_o,
  output logic [branch_metadata_fwd_width_p-1:0] redirect_br_metadata_fwd_o,
  output logic                                   redirect_br_taken_o,
  output logic                                   redirect_br_ntaken_o,
  output logic                                   redirect_br_nonbr_o,
  output logic                                   attaboy_v_o,
  output logic [vaddr_width_p-1:0]               attaboy_pc_o,
  output logic [branch_metadata_fwd_width_p-1:0] attaboy_br_metadata_fwd_o,
  output logic                                   attaboy_taken_o,
  output logic                                   attaboy_ntaken_o,
  input  logic                                   attaboy_yumi_i,
  output logic                                   ready_o,
  output logic [31:0]                            perf_attaboy_o,
  output logic [31:0]                            perf_drop_o,
  output logic [31:0]                            perf_redirect_o
);

  localparam int ptr_w_lp = $clog2(attaboy_els_p);
  localparam logic [ptr_w_lp:0] ptr_one_lp = {{ptr_w_lp{1'b0}}, 1'b1};

  typedef enum logic [0:0] {e_init = 1'b0, e_run = 1'b1} state_e;

  typedef struct packed {
    logic                                   v;
    logic [vaddr_width_p-1:0]               pc;
    logic                                   resume;
    logic                                   br_v;
    logic [branch_metadata_fwd_width_p-1:0] md;
    logic                                   taken;
    logic                                   ntaken;
    logic                                   nonbr;
  } redir_t;

  typedef struct packed {
    logic [vaddr_width_p-1:0]               pc;
    logic [branch_metadata_fwd_width_p-1:0] md;
    logic                                   taken;
  } ab_t;

  state_e state_r, state_n_s;
  redir_t redir_r, redir_n_s;
  ab_t    mem_r [attaboy_els_p];
  logic [ptr_w_lp:0] wptr_r, rptr_r;
  logic run_s, cmd_redir_s, br_redir_s, enq_s, empty_s, full_s, pop_s, push_s;
  ab_t  head_s;

  // FSM state register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_init;
    else            state_r <= state_n_s;
  end

  // FSM next state: leaves init once FE tables are ready, then stays in run
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      e_init:  if (fe_init_done_i) state_n_s = e_run; else state_n_s = e_init;
      e_run:   state_n_s = e_run;
      default: state_n_s = e_init;
    endcase
  end

  assign run_s       = (state_r == e_run);
  assign cmd_redir_s = run_s & cmd_redirect_v_i;
  assign br_redir_s  = run_s & br_v_i & (br_mispredict_i | br_nonbr_i) & ~cmd_redirect_v_i;
  assign enq_s       = run_s & br_v_i & ~br_mispredict_i & ~br_nonbr_i & ~cmd_redirect_v_i;

  // Redirect next payload: command redirects win; payload holds between pulses
  always_comb begin
    redir_n_s   = redir_r;
    redir_n_s.v = 1'b0;
    if (cmd_redir_s) begin
      redir_n_s = '{v: 1'b1, pc: cmd_redirect_pc_i, resume: 1'b0, br_v: 1'b0,
                    md: '0, taken: 1'b0, ntaken: 1'b0, nonbr: 1'b0};
    end else if (br_redir_s) begin
      redir_n_s = '{v: 1'b1, pc: br_pc_i, resume: br_resume_i, br_v: 1'b1, md: br_metadata_i,
                    taken: br_taken_i & ~br_nonbr_i, ntaken: ~br_taken_i & ~br_nonbr_i,
                    nonbr: br_nonbr_i};
    end else begin
      redir_n_s.v = 1'b0;
    end
  end

  // Redirect output register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) redir_r <= '0;
    else            redir_r <= redir_n_s;
  end

  assign redirect_v_o               = redir_r.v;
  assign redirect_pc_o              = redir_r.pc;
  assign redirect_resume_o          = redir_r.resume;
  assign redirect_br_v_o            = redir_r.br_v;
  assign redirect_br_metadata_fwd_o = redir_r.md;
  assign redirect_br_taken_o        = redir_r.taken;
  assign redirect_br_ntaken_o       = redir_r.ntaken;
  assign redirect_br_nonbr_o        = redir_r.nonbr;

  // A full FIFO still accepts an enqueue when the head is popped in the same cycle
  assign empty_s = (wptr_r == rptr_r);
  assign full_s  = (wptr_r[ptr_w_lp-1:0] == rptr_r[ptr_w_lp-1:0]) &
                   (wptr_r[ptr_w_lp] != rptr_r[ptr_w_lp]);
  assign pop_s   = attaboy_yumi_i & ~empty_s;
  assign push_s  = enq_s & (~full_s | pop_s);

  // Attaboy FIFO storage and pointers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      for (int i = 0; i < attaboy_els_p; i++) mem_r[i] <= '0;
    end else begin
      if (push_s) begin
        mem_r[wptr_r[ptr_w_lp-1:0]] <= '{pc: br_pc_i, md: br_metadata_i, taken: br_taken_i};
        wptr_r <= wptr_r + ptr_one_lp;
      end
      if (pop_s) rptr_r <= rptr_r + ptr_one_lp;
    end
  end

  assign head_s                    = mem_r[rptr_r[ptr_w_lp-1:0]];
  assign attaboy_v_o               = ~empty_s;
  assign attaboy_pc_o              = head_s.pc;
  assign attaboy_br_metadata_fwd_o = head_s.md;
  assign attaboy_taken_o           = head_s.taken;
  assign attaboy_ntaken_o          = ~head_s.taken & ~empty_s;
  assign ready_o                   = run_s;

`ifdef BP_FE_FEEDBACK_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] c, input logic en);
    if (en && (c != 32'hFFFF_FFFF)) return c + 32'd1;
    else                            return c;
  endfunction

  logic [31:0] perf_attaboy_r, perf_drop_r, perf_redirect_r;
  logic        drop_s;
  assign drop_s = enq_s & full_s & ~pop_s;

  // Saturating event counters
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      perf_attaboy_r  <= 32'd0;
      perf_drop_r     <= 32'd0;
      perf_redirect_r <= 32'd0;
    end else begin
      perf_attaboy_r  <= sat_inc(perf_attaboy_r, pop_s);
      perf_drop_r     <= sat_inc(perf_drop_r, drop_s);
      perf_redirect_r <= sat_inc(perf_redirect_r, cmd_redir_s | br_redir_s);
    end
  end

  assign perf_attaboy_o  = perf_attaboy_r;
  assign perf_drop_o     = perf_drop_r;
  assign perf_redirect_o = perf_redirect_r;
`else
  assign perf_attaboy_o  = 32'b0;
  assign perf_drop_o     = 32'b0;
  assign perf_redirect_o = 32'b0;
`endif

endmodule
